// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: control sequencer for the time-multiplexed FIR datapath
// Accumulator control codes shared with the accumulator; kept in this file so the
// block is self-contained.
// Ports: clk/rst_n (async active-low), in_valid/in_ready sample handshake,
// flush_in zeroes the delay line and clears the accumulator, sample_addr/sample_we/
// sample_zero drive the delay-line RAM, coef_addr the coefficient ROM, ctrl_out the
// accumulator, out_valid pulses when acc_out is final, busy is high outside IDLE.
package fir_filter_pkg;
  localparam logic [1:0] MAC_NOP  = 2'd0;
  localparam logic [1:0] MAC_LOAD = 2'd1;
  localparam logic [1:0] MAC_ACC  = 2'd2;
  localparam logic [1:0] MAC_CLR  = 2'd3;
endpackage

module fir_mac_sequencer
  import fir_filter_pkg::*;
#(
  parameter int TAPS = 8,
  parameter int PIPE_LAT = 2,
  localparam int AW = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush_in,
  output logic [AW-1:0] sample_addr,
  output logic          sample_we,
  output logic          sample_zero,
  output logic [AW-1:0] coef_addr,
  output logic [1:0]    ctrl_out,
  output logic          out_valid,
  output logic          busy
);
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam int PW = 2 * PIPE_LAT;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  typedef enum logic [2:0] {FLUSH, IDLE, MAC, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] k_q, k_d, wr_ptr_q, wr_ptr_d, nxt_ptr, rd_addr;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [PW-1:0] pipe_q, pipe_d;
  logic [1:0] issue, pipe_out;
  assign nxt_ptr = wr_ptr_q == LAST ? '0 : wr_ptr_q + AW'(1);
  // Wrap modulo TAPS, not 2^AW, so non-power-of-two tap counts index correctly.
  assign rd_addr = wr_ptr_q >= k_q ? wr_ptr_q - k_q : wr_ptr_q + AW'(TAPS) - k_q;
  // Control codes ride a PIPE_LAT-deep shift register to line up with mul_in.
  assign pipe_d = (pipe_q << 2) | PW'(issue);
  assign pipe_out = pipe_q[PW-1 -: 2];
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    wr_ptr_d = wr_ptr_q;
    dcnt_d = dcnt_q;
    issue = MAC_NOP;
    in_ready = 1'b0;
    out_valid = 1'b0;
    sample_we = 1'b0;
    sample_zero = 1'b0;
    sample_addr = '0;
    coef_addr = '0;
    ctrl_out = pipe_out;
    case (state_q)
      FLUSH: begin
        // Gated by rst_n so the write strobes and MAC_CLR stay quiet while reset is held.
        sample_we = rst_n;
        sample_zero = rst_n;
        sample_addr = k_q;
        ctrl_out = (k_q == '0 && rst_n) ? MAC_CLR : pipe_out;
        k_d = k_q == LAST ? '0 : k_q + AW'(1);
        state_d = k_q == LAST ? IDLE : FLUSH;
        wr_ptr_d = k_q == LAST ? LAST : wr_ptr_q;
      end
      IDLE: begin
        in_ready = !flush_in;
        if (flush_in) begin
          state_d = FLUSH;
          k_d = '0;
        end else if (in_valid) begin
          sample_we = 1'b1;
          sample_addr = nxt_ptr;
          wr_ptr_d = nxt_ptr;
          k_d = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        coef_addr = k_q;
        sample_addr = rd_addr;
        issue = k_q == '0 ? MAC_LOAD : MAC_ACC;
        k_d = k_q == LAST ? '0 : k_q + AW'(1);
        dcnt_d = '0;
        state_d = k_q == LAST ? DRAIN : MAC;
      end
      DRAIN: begin
        dcnt_d = dcnt_q == DW'(PIPE_LAT - 1) ? '0 : dcnt_q + DW'(1);
        state_d = dcnt_q == DW'(PIPE_LAT - 1) ? DONE : DRAIN;
      end
      DONE: begin
        out_valid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = FLUSH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FLUSH;
      k_q <= '0;
      wr_ptr_q <= LAST;
      dcnt_q <= '0;
      pipe_q <= {PIPE_LAT{MAC_NOP}};
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      wr_ptr_q <= wr_ptr_d;
      dcnt_q <= dcnt_d;
      pipe_q <= pipe_d;
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: randomized self-checking bench against a timing-formula model
module tb_fir_mac_sequencer;
  import fir_filter_pkg::*;
  localparam int T = 4;
  localparam int PL = 2;
  localparam logic [11:0] RST_V = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, MAC_NOP};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic flush_in = 1'b0;
  logic in_ready, sample_we, sample_zero, out_valid, busy;
  logic [1:0] sample_addr, coef_addr, ctrl_out;
  int errors = 0;
  int checks = 0;
  int m_mode, m_t, m_wr;
  fir_mac_sequencer #(.TAPS(T), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush_in(flush_in), .sample_addr(sample_addr), .sample_we(sample_we),
    .sample_zero(sample_zero), .coef_addr(coef_addr), .ctrl_out(ctrl_out),
    .out_valid(out_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] obs();
    return {in_ready, out_valid, busy, sample_we, sample_zero, sample_addr, coef_addr, ctrl_out};
  endfunction
  // Model: mode 0 = flushing (t = flush cycle), 1 = idle, 2 = busy (t = cycles since handshake).
  function automatic logic [11:0] exp_vec(input logic iv, input logic fl);
    logic rdy, ov, bsy, we, z;
    logic [1:0] sa, ca, ct;
    rdy = 0; ov = 0; bsy = 1; we = 0; z = 0; sa = 0; ca = 0; ct = MAC_NOP;
    if (m_mode == 0) begin
      we = 1; z = 1; sa = 2'(m_t);
      ct = m_t == 0 ? MAC_CLR : MAC_NOP;
    end else if (m_mode == 1) begin
      bsy = 0;
      rdy = !fl;
      if (!fl && iv) begin
        we = 1;
        sa = 2'((m_wr + 1) % T);
      end
    end else begin
      ov = m_t == T + PL + 1;
      if (m_t <= T) begin
        ca = 2'(m_t - 1);
        sa = 2'((m_wr - (m_t - 1) + T) % T);
      end
      ct = m_t == PL + 1 ? MAC_LOAD : (m_t >= PL + 2 && m_t <= T + PL) ? MAC_ACC : MAC_NOP;
    end
    return {rdy, ov, bsy, we, z, sa, ca, ct};
  endfunction
  task automatic model_next(input logic iv, input logic fl);
    if (m_mode == 0) begin
      m_t++;
      if (m_t == T) begin m_mode = 1; m_t = 0; m_wr = T - 1; end
    end else if (m_mode == 1) begin
      if (fl) begin m_mode = 0; m_t = 0; end
      else if (iv) begin m_mode = 2; m_t = 1; m_wr = (m_wr + 1) % T; end
    end else begin
      m_t++;
      if (m_t > T + PL + 1) begin m_mode = 1; m_t = 0; end
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_t = 0; m_wr = T - 1;
  endtask
  task automatic test_reset();
    in_valid = 0; flush_in = 0;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== RST_V) begin errors++; $display("FAIL reset_state: got %h exp %h", obs(), RST_V); end
    @(posedge clk);
    #2 rst_n = 1;
    model_reset();
    for (int c = 0; c < T + 2; c++) begin
      @(negedge clk); in_valid = 0; flush_in = 0; #1;
      checks++;
      if (obs() !== exp_vec(in_valid, flush_in)) begin errors++; $display("FAIL reset_release cyc %0d: got %h exp %h", c, obs(), exp_vec(in_valid, flush_in)); end
      model_next(in_valid, flush_in);
    end
  endtask
  task automatic test_single();
    int gap = $urandom_range(0, 3);
    for (int c = 0; c < gap + T + PL + 4; c++) begin
      @(negedge clk); in_valid = (c == gap); flush_in = 0; #1;
      checks++;
      if (obs() !== exp_vec(in_valid, flush_in)) begin errors++; $display("FAIL single cyc %0d: got %h exp %h", c, obs(), exp_vec(in_valid, flush_in)); end
      model_next(in_valid, flush_in);
    end
  endtask
  task automatic test_wrap();
    logic [1:0] got[$];
    logic [1:0] want[5];
    want = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int c = 0; c < 1 + T + 5 * (T + PL + 2); c++) begin
      @(negedge clk); in_valid = 1; flush_in = (c == 0); #1;
      if (sample_we && !sample_zero) got.push_back(sample_addr);
      checks++;
      if (obs() !== exp_vec(in_valid, flush_in)) begin errors++; $display("FAIL wrap cyc %0d: got %h exp %h", c, obs(), exp_vec(in_valid, flush_in)); end
      model_next(in_valid, flush_in);
    end
    in_valid = 0;
    checks++;
    if (got.size() != 5) begin errors++; $display("FAIL wrap_count: got %0d exp 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== want[i]) begin errors++; $display("FAIL wrap_addr %0d: got %0d exp %0d", i, got[i], want[i]); end
    end
    for (int c = 0; c < T + PL + 2; c++) begin
      @(negedge clk); in_valid = 0; flush_in = 0; #1;
      checks++;
      if (obs() !== exp_vec(in_valid, flush_in)) begin errors++; $display("FAIL wrap_tail cyc %0d: got %h exp %h", c, obs(), exp_vec(in_valid, flush_in)); end
      model_next(in_valid, flush_in);
    end
  endtask
  task automatic test_flush_priority();
    for (int c = 0; c < T + 2 + T + PL + 2; c++) begin
      @(negedge clk); in_valid = (c == 0 || c == T + 1); flush_in = (c == 0); #1;
      if (c == 0) begin
        checks++;
        if (in_ready !== 1'b0 || sample_we !== 1'b0) begin errors++; $display("FAIL flush_prio_handshake: got rdy=%b we=%b exp rdy=0 we=0", in_ready, sample_we); end
      end
      if (c == 1) begin
        checks++;
        if (ctrl_out !== MAC_CLR) begin errors++; $display("FAIL flush_prio_clr: got %0d exp %0d", ctrl_out, MAC_CLR); end
      end
      if (c == T + 1) begin
        checks++;
        if (sample_we !== 1'b1 || sample_addr !== 2'd0) begin errors++; $display("FAIL flush_prio_next_addr: got we=%b addr=%0d exp we=1 addr=0", sample_we, sample_addr); end
      end
      checks++;
      if (obs() !== exp_vec(in_valid, flush_in)) begin errors++; $display("FAIL flush_prio cyc %0d: got %h exp %h", c, obs(), exp_vec(in_valid, flush_in)); end
      model_next(in_valid, flush_in);
    end
  endtask
  task automatic test_noise();
    int ov_cnt = 0;
    int ov_cyc = -1;
    for (int c = 0; c < T + PL + 3; c++) begin
      @(negedge clk);
      in_valid = c == 0 ? 1'b1 : (c <= T + PL + 1 ? 1'($urandom_range(0, 1)) : 1'b0);
      flush_in = (c >= 1 && c <= T + PL + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (out_valid) begin ov_cnt++; ov_cyc = c; end
      checks++;
      if (obs() !== exp_vec(in_valid, flush_in)) begin errors++; $display("FAIL noise cyc %0d: got %h exp %h", c, obs(), exp_vec(in_valid, flush_in)); end
      model_next(in_valid, flush_in);
    end
    checks++;
    if (ov_cnt != 1 || ov_cyc != T + PL + 1) begin errors++; $display("FAIL noise_out_valid: got cnt=%0d cyc=%0d exp cnt=1 cyc=%0d", ov_cnt, ov_cyc, T + PL + 1); end
  endtask
  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); in_valid = (c == 0); flush_in = 0; #1;
      checks++;
      if (obs() !== exp_vec(in_valid, flush_in)) begin errors++; $display("FAIL reset_mid_pre cyc %0d: got %h exp %h", c, obs(), exp_vec(in_valid, flush_in)); end
      if (c < 3) model_next(in_valid, flush_in);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if (obs() !== RST_V) begin errors++; $display("FAIL reset_mid_async: got %h exp %h", obs(), RST_V); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); in_valid = 1; flush_in = 0; #1;
      checks++;
      if (obs() !== RST_V) begin errors++; $display("FAIL reset_mid_hold cyc %0d: got %h exp %h", c, obs(), RST_V); end
    end
    in_valid = 0;
    @(posedge clk);
    #2 rst_n = 1;
    model_reset();
    for (int c = 0; c < T + 1 + T + PL + 3; c++) begin
      @(negedge clk); in_valid = (c == T); flush_in = 0; #1;
      checks++;
      if (obs() !== exp_vec(in_valid, flush_in)) begin errors++; $display("FAIL reset_mid_after cyc %0d: got %h exp %h", c, obs(), exp_vec(in_valid, flush_in)); end
      model_next(in_valid, flush_in);
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 3) != 0;
      flush_in = $urandom_range(0, 15) == 0;
      #1;
      checks++;
      if (obs() !== exp_vec(in_valid, flush_in)) begin errors++; $display("FAIL random cyc %0d: got %h exp %h", c, obs(), exp_vec(in_valid, flush_in)); end
      model_next(in_valid, flush_in);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_flush_priority();
    test_noise();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
